// File: rtl/clink_pkg.sv
// Shared types and constants for the hidden-state update stage.
//   DW/FRAC/ACCW : data width, fractional bits (Q7.8), accumulator width
//   HT_MAX/MIN   : hard-tanh clip limits (+1.0 / -1.0)
//   state_e      : controller states; mac_op_t : MAC operand pair
package clink_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned FRAC  = 8;
  localparam int unsigned ACCW  = 26;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned NNODE = 5;
  localparam int unsigned NTERM = 6;

  localparam logic signed [DW-1:0] ONE    = 16'sh0100;
  localparam logic signed [DW-1:0] HT_MAX = 16'sh0100;
  localparam logic signed [DW-1:0] HT_MIN = 16'shFF00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
  } mac_op_t;

  // Clip an accumulator value to [-1.0, +1.0] and narrow to DW.
  function automatic logic signed [DW-1:0] hardtanh(input logic signed [ACCW-1:0] x);
    logic signed [DW-1:0] y;
    if (x > ACCW'(HT_MAX)) begin
      y = HT_MAX;
    end else if (x < ACCW'(HT_MIN)) begin
      y = HT_MIN;
    end else begin
      y = DW'(x);
    end
    return y;
  endfunction

endpackage

// File: rtl/clink_hidden_update_mac.sv
// Time-shared signed fixed-point multiply-accumulate.
//   clock, reset_n : clock / async active-low reset
//   op             : operand pair (a*b)
//   en             : update the accumulator this cycle
//   load           : start a new sum with this product instead of adding
//   sum_c          : combinational next accumulator value (the sum including this product)
module clink_mac_unit
  import clink_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  mac_op_t                op,
  input  logic                   en,
  input  logic                   load,
  output logic signed [ACCW-1:0] sum_c
);

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] term;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_d;

  // Full-width product, rescaled by FRAC with an arithmetic shift (rounds toward -inf).
  always_comb begin
    prod  = PW'(op.a) * PW'(op.b);
    term  = ACCW'(prod >>> FRAC);
    acc_d = load ? term : acc_q + term;
    sum_c = acc_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/clink_hidden_update.sv
// Hidden-state update: computes the 5 new hidden states of one inference with
// a single shared MAC (30 cycles), then pulses clink_done.
//   clock, reset_n        : clock / async active-low reset
//   clink_start           : start pulse, accepted in IDLE only
//   in_d, h1..h5_pre_d    : latched input sample and previous hidden states
//   rec_wb, rec_w1..w5    : input weight and circulant recurrent weights
//   h1..h5_cur_d          : new hidden states, held until overwritten
//   busy                  : high through RUN and DONE
//   clink_done            : one-cycle pulse when all results are valid
module clink_hidden_update
  import clink_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clink_start,
  input  logic signed [DW-1:0] in_d,
  input  logic signed [DW-1:0] h1_pre_d,
  input  logic signed [DW-1:0] h2_pre_d,
  input  logic signed [DW-1:0] h3_pre_d,
  input  logic signed [DW-1:0] h4_pre_d,
  input  logic signed [DW-1:0] h5_pre_d,
  input  logic signed [DW-1:0] rec_wb,
  input  logic signed [DW-1:0] rec_w1,
  input  logic signed [DW-1:0] rec_w2,
  input  logic signed [DW-1:0] rec_w3,
  input  logic signed [DW-1:0] rec_w4,
  input  logic signed [DW-1:0] rec_w5,
  output logic signed [DW-1:0] h1_cur_d,
  output logic signed [DW-1:0] h2_cur_d,
  output logic signed [DW-1:0] h3_cur_d,
  output logic signed [DW-1:0] h4_cur_d,
  output logic signed [DW-1:0] h5_cur_d,
  output logic                 busy,
  output logic                 clink_done
);

  state_e               state_q, state_d;
  logic [2:0]           k_q, k_d;
  logic [2:0]           t_q, t_d;
  logic signed [DW-1:0] hout_q [NNODE];
  logic signed [DW-1:0] hout_d [NNODE];
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic signed [DW-1:0] w     [NTERM];
  logic signed [DW-1:0] h_pre [NNODE];
  logic [2:0]           j;
  logic [3:0]           cidx;
  logic [2:0]           wsel;
  mac_op_t              mac_op;
  logic                 mac_en;
  logic                 mac_load;
  logic signed [ACCW-1:0] mac_sum_c;

  assign w[0] = rec_wb;
  assign w[1] = rec_w1;
  assign w[2] = rec_w2;
  assign w[3] = rec_w3;
  assign w[4] = rec_w4;
  assign w[5] = rec_w5;

  assign h_pre[0] = h1_pre_d;
  assign h_pre[1] = h2_pre_d;
  assign h_pre[2] = h3_pre_d;
  assign h_pre[3] = h4_pre_d;
  assign h_pre[4] = h5_pre_d;

  // Operand select: t=0 is the input term; otherwise weight w[((j-k) mod 5)+1] times h_pre[j].
  always_comb begin
    j         = '0;
    cidx      = '0;
    wsel      = '0;
    mac_op.a  = w[0];
    mac_op.b  = in_d;
    if (t_q != 3'd0) begin
      j    = t_q - 3'd1;
      cidx = 4'(j) + 4'(NNODE) - 4'(k_q);
      if (cidx >= 4'(NNODE)) begin
        cidx = cidx - 4'(NNODE);
      end
      wsel     = 3'(cidx) + 3'd1;
      mac_op.a = w[wsel];
      mac_op.b = h_pre[j];
    end
  end

  clink_mac_unit u_mac (
    .clock   (clock),
    .reset_n (reset_n),
    .op      (mac_op),
    .en      (mac_en),
    .load    (mac_load),
    .sum_c   (mac_sum_c)
  );

  // Controller: node counter k (outer) and term counter t (inner), one MAC per RUN cycle.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    t_d      = t_q;
    hout_d   = hout_q;
    mac_en   = 1'b0;
    mac_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clink_start) begin
          state_d = RUN;
          k_d     = '0;
          t_d     = '0;
        end
      end
      RUN: begin
        mac_en   = 1'b1;
        mac_load = (t_q == 3'd0);
        if (t_q == 3'(NTERM - 1)) begin
          hout_d[k_q] = hardtanh(mac_sum_c);
          t_d         = '0;
          if (k_q == 3'(NNODE - 1)) begin
            state_d = DONE;
          end else begin
            k_d = k_q + 3'd1;
          end
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      t_q     <= '0;
      hout_q  <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      hout_q  <= hout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign h1_cur_d   = hout_q[0];
  assign h2_cur_d   = hout_q[1];
  assign h3_cur_d   = hout_q[2];
  assign h4_cur_d   = hout_q[3];
  assign h5_cur_d   = hout_q[4];
  assign busy       = busy_q;
  assign clink_done = done_q;

endmodule

// File: tb/tb_clink_hidden_update.sv
// Directed bench for clink_hidden_update with hand-computed expectations.
module tb_clink_hidden_update;

  logic        clock;
  logic        reset_n;
  logic        clink_start;
  logic [15:0] in_d;
  logic [15:0] pv [5];
  logic [15:0] wb;
  logic [15:0] wv [5];
  logic [15:0] h1, h2, h3, h4, h5;
  logic        busy;
  logic        clink_done;

  int n_tests = 0;
  int n_fail  = 0;

  clink_hidden_update dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clink_start (clink_start),
    .in_d        (in_d),
    .h1_pre_d    (pv[0]),
    .h2_pre_d    (pv[1]),
    .h3_pre_d    (pv[2]),
    .h4_pre_d    (pv[3]),
    .h5_pre_d    (pv[4]),
    .rec_wb      (wb),
    .rec_w1      (wv[0]),
    .rec_w2      (wv[1]),
    .rec_w3      (wv[2]),
    .rec_w4      (wv[3]),
    .rec_w5      (wv[4]),
    .h1_cur_d    (h1),
    .h2_cur_d    (h2),
    .h3_cur_d    (h3),
    .h4_cur_d    (h4),
    .h5_cur_d    (h5),
    .busy        (busy),
    .clink_done  (clink_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_h(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                         input logic [15:0] e3, input logic [15:0] e4, input logic [15:0] e5);
    check({tag, "_h1"}, 32'(h1), 32'(e1));
    check({tag, "_h2"}, 32'(h2), 32'(e2));
    check({tag, "_h3"}, 32'(h3), 32'(e3));
    check({tag, "_h4"}, 32'(h4), 32'(e4));
    check({tag, "_h5"}, 32'(h5), 32'(e5));
  endtask

  task automatic set_vec(input logic [15:0] b, input logic [15:0] x,
                         input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3,
                         input logic [15:0] w4, input logic [15:0] w5,
                         input logic [15:0] p1, input logic [15:0] p2, input logic [15:0] p3,
                         input logic [15:0] p4, input logic [15:0] p5);
    wb = b; in_d = x;
    wv[0] = w1; wv[1] = w2; wv[2] = w3; wv[3] = w4; wv[4] = w5;
    pv[0] = p1; pv[1] = p2; pv[2] = p3; pv[3] = p4; pv[4] = p5;
  endtask

  // Start in cycle 0, optionally pulse start again in cycle extra_cyc, and
  // check done timing, pulse count and busy in cycles 1, 31, 32.
  task automatic do_inf(input string tag, input int extra_cyc);
    int         done_cyc;
    int         n_done;
    logic [2:0] bsamp;
    done_cyc = -1;
    n_done   = 0;
    bsamp    = 3'bxxx;
    @(posedge clock); #1;
    clink_start = 1'b1;
    @(posedge clock); #1;
    clink_start = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      clink_start = (cyc == extra_cyc);
      @(negedge clock);
      if (clink_done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 1)  bsamp[2] = busy;
      if (cyc == 31) bsamp[1] = busy;
      if (cyc == 32) bsamp[0] = busy;
      @(posedge clock); #1;
    end
    clink_start = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'd31);
    check({tag, "_done_count"}, 32'(n_done), 32'd1);
    check({tag, "_busy_1_31_32"}, 32'(bsamp), 32'b110);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n     = 1'b0;
    clink_start = 1'b0;
    set_vec(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_h("reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(clink_done), 32'd0);

    // Input path only: 1.0 * 0.5
    set_vec(16'h0100, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    do_inf("input", 0);
    check_h("input", 16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0080);

    // Circulant weight selection
    set_vec(16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h10, 16'h20, 16'h30, 16'h40, 16'h50);
    do_inf("circ_w1", 0);
    check_h("circ_w1", 16'h10, 16'h20, 16'h30, 16'h40, 16'h50);

    set_vec(16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0,
            16'h10, 16'h20, 16'h30, 16'h40, 16'h50);
    do_inf("circ_w2", 0);
    check_h("circ_w2", 16'h20, 16'h30, 16'h40, 16'h50, 16'h10);

    set_vec(16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0,
            16'h10, 16'h20, 16'h30, 16'h40, 16'h50);
    do_inf("circ_w3", 0);
    check_h("circ_w3", 16'h30, 16'h40, 16'h50, 16'h10, 16'h20);

    // Saturation both ways
    set_vec(16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    do_inf("sat_pos", 0);
    check_h("sat_pos", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);

    set_vec(16'h8000, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    do_inf("sat_neg", 0);
    check_h("sat_neg", 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);

    // -1/256 * 0.5 = -128 before the shift, -1 after
    set_vec(16'hFFFF, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    do_inf("trunc", 0);
    check_h("trunc", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // 0.25 + 0.5*h_k ; start in the DONE cycle must not be accepted
    set_vec(16'h0100, 16'h0040, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h10, 16'h20, 16'h30, 16'h40, 16'h50);
    do_inf("mix_pos_start31", 31);
    check_h("mix_pos", 16'h48, 16'h50, 16'h58, 16'h60, 16'h68);

    // 0.25 - 0.5*h_k ; start in RUN cycle 10 is ignored
    set_vec(16'h0100, 16'h0040, 16'hFF80, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h10, 16'h20, 16'h30, 16'h40, 16'h50);
    do_inf("mix_neg_start10", 10);
    check_h("mix_neg", 16'h38, 16'h30, 16'h28, 16'h20, 16'h18);

    // Reset during RUN at cycle 15 discards everything
    set_vec(16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(posedge clock); #1;
    clink_start = 1'b1;
    @(posedge clock); #1;
    clink_start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    check("midrun_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_h("midrun_reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(clink_done), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("after_reset_idle_busy", 32'(busy), 32'd0);
    check_h("after_reset_hold", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    set_vec(16'h0100, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    do_inf("post_reset", 0);
    check_h("post_reset", 16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0080);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
